// File: rtl/compressor_input_arbiter_if.sv
// Handshake bundle between N AXI-stream sources, the input arbiter and the compressor.
// The slave modport is the arbiter's view; master is the view of whatever drives sources and sink.
interface compressor_input_arbiter_if #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 256,
  parameter int TKEEP_WIDTH = 32,
  parameter int SID_WIDTH   = 3
);
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  data_in;
  logic [NUM_SRC-1:0][TKEEP_WIDTH-1:0] tkeep_in;
  logic [NUM_SRC-1:0]                  tvalid_in;
  logic [NUM_SRC-1:0]                  tlast_in;
  logic [NUM_SRC-1:0]                  tready_out;
  logic [DATA_WIDTH-1:0]               data_out;
  logic [TKEEP_WIDTH-1:0]              tkeep_out;
  logic                                tvalid_out;
  logic                                tlast_out;
  logic                                tready_in;
  logic [SID_WIDTH-1:0]                sid_out;
  logic                                busy_out;
  logic [31:0]                         pkt_count_out;

  modport master (
    output data_in, tkeep_in, tvalid_in, tlast_in, tready_in,
    input  tready_out, data_out, tkeep_out, tvalid_out, tlast_out,
           sid_out, busy_out, pkt_count_out
  );

  modport slave (
    input  data_in, tkeep_in, tvalid_in, tlast_in, tready_in,
    output tready_out, data_out, tkeep_out, tvalid_out, tlast_out,
           sid_out, busy_out, pkt_count_out
  );
endinterface

// File: rtl/compressor_input_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-stream sources into one compressor input.
// Grant is registered (one-cycle arbitration) and held until the tlast beat is accepted.
module compressor_input_arbiter #(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 256,
  parameter int TKEEP_WIDTH = 32,
  parameter int SID_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  compressor_input_arbiter_if.slave bus
);
  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_nxt;
  logic [GW-1:0]           grant, last_grant, scan_grant, scan_idx;
  logic                    scan_hit, accept, pkt_done;
  logic [31:0]             pkt_count;
  logic [DATA_WIDTH-1:0]   mux_data;
  logic [TKEEP_WIDTH-1:0]  mux_keep;

  // Round-robin scan starting one past the last source that finished a packet.
  always_comb begin
    scan_hit   = 1'b0;
    scan_grant = last_grant;
    scan_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan_idx = GW'((int'(last_grant) + k) % NUM_SRC);
      if (!scan_hit && bus.tvalid_in[scan_idx]) begin
        scan_hit   = 1'b1;
        scan_grant = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= '0;
      last_grant <= GW'(NUM_SRC - 1);
      pkt_count  <= '0;
    end else begin
      if (state == IDLE && scan_hit) grant <= scan_grant;
      if (pkt_done) begin
        last_grant <= grant;
        pkt_count  <= pkt_count + 32'd1;
      end
    end
  end

  // Outputs are forced to zero outside BUSY so reset clears them without waiting for a clock.
  always_comb begin
    state_nxt      = state;
    mux_data       = '0;
    mux_keep       = '0;
    bus.tready_out = '0;
    bus.tvalid_out = 1'b0;
    bus.tlast_out  = 1'b0;
    accept         = 1'b0;
    pkt_done       = 1'b0;
    case (state)
      IDLE: begin
        if (scan_hit) state_nxt = BUSY;
      end
      BUSY: begin
        mux_data              = bus.data_in[grant];
        mux_keep              = bus.tkeep_in[grant];
        bus.tlast_out         = bus.tlast_in[grant];
        bus.tvalid_out        = bus.tvalid_in[grant];
        bus.tready_out[grant] = bus.tready_in;
        accept                = bus.tvalid_out & bus.tready_in;
        pkt_done              = accept & bus.tlast_out;
        if (pkt_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.data_out      = mux_data;
  assign bus.tkeep_out     = mux_keep;
  assign bus.busy_out      = (state == BUSY);
  assign bus.sid_out       = SID_WIDTH'(grant);
  assign bus.pkt_count_out = pkt_count;
endmodule

// File: tb/tb_compressor_input_arbiter.sv
// Directed bench for compressor_input_arbiter: grant order, packet hold, stalls, gaps and async reset.
module tb_compressor_input_arbiter;
  localparam int NS = 4, DW = 256, KW = 32, SW = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  compressor_input_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW), .TKEEP_WIDTH(KW), .SID_WIDTH(SW)) bus ();

  compressor_input_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .TKEEP_WIDTH(KW), .SID_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_data(input logic [1:0] s, input int b);
    logic [7:0] bb;
    bb = b[7:0];
    return {8{32'hC0DE_0000 | {22'd0, s, bb}}};
  endfunction

  function automatic logic [KW-1:0] exp_keep(input logic [1:0] s, input int b);
    logic [7:0] bb;
    bb = b[7:0];
    return 32'hFFFF_0000 | {22'd0, s, bb};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] s, input int b, input logic last);
    bus.data_in[s]   = exp_data(s, b);
    bus.tkeep_in[s]  = exp_keep(s, b);
    bus.tlast_in[s]  = last;
    bus.tvalid_in[s] = 1'b1;
  endtask

  task automatic clear_inputs();
    bus.data_in   = '0;
    bus.tkeep_in  = '0;
    bus.tvalid_in = '0;
    bus.tlast_in  = '0;
    bus.tready_in = 1'b1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    drive(2'd1, 7, 1'b1);
    cyc();
    cyc();
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.busy_out); end
    checks++; if (bus.tvalid_out !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b exp 0", bus.tvalid_out); end
    checks++; if (bus.tready_out !== 4'b0000) begin errors++; $display("FAIL reset_tready got %b exp 0000", bus.tready_out); end
    checks++; if (bus.tlast_out !== 1'b0) begin errors++; $display("FAIL reset_tlast got %0b exp 0", bus.tlast_out); end
    checks++; if (bus.sid_out !== 3'd0) begin errors++; $display("FAIL reset_sid got %0d exp 0", bus.sid_out); end
    checks++; if (bus.data_out !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.data_out); end
    checks++; if (bus.tkeep_out !== '0) begin errors++; $display("FAIL reset_tkeep got %h exp 0", bus.tkeep_out); end
    checks++; if (bus.pkt_count_out !== 32'd0) begin errors++; $display("FAIL reset_pkt got %0d exp 0", bus.pkt_count_out); end
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_source();
    drive(2'd2, 0, 1'b0);
    #1;
    checks++; if (bus.busy_out !== 1'b0 || bus.tvalid_out !== 1'b0 || bus.tready_out !== 4'b0000) begin
      errors++; $display("FAIL single_idle busy %0b tvalid %0b tready %b exp 0 0 0000", bus.busy_out, bus.tvalid_out, bus.tready_out); end
    cyc();
    for (int b = 0; b < 3; b++) begin
      #1;
      checks++; if (bus.sid_out !== 3'd2 || bus.busy_out !== 1'b1) begin
        errors++; $display("FAIL single_sid beat %0d got sid %0d busy %0b exp 2 1", b, bus.sid_out, bus.busy_out); end
      checks++; if (bus.data_out !== exp_data(2'd2, b) || bus.tkeep_out !== exp_keep(2'd2, b)) begin
        errors++; $display("FAIL single_data beat %0d got %h/%h exp %h/%h", b, bus.data_out[31:0], bus.tkeep_out, exp_data(2'd2, b), exp_keep(2'd2, b)); end
      checks++; if (bus.tlast_out !== (b == 2) || bus.tready_out !== 4'b0100) begin
        errors++; $display("FAIL single_ctl beat %0d got tlast %0b tready %b exp %0b 0100", b, bus.tlast_out, bus.tready_out, (b == 2)); end
      cyc();
      if (b < 2) drive(2'd2, b + 1, (b + 1) == 2);
      else bus.tvalid_in[2] = 1'b0;
    end
    #1;
    checks++; if (bus.busy_out !== 1'b0 || bus.pkt_count_out !== 32'd1) begin
      errors++; $display("FAIL single_done got busy %0b pkt %0d exp 0 1", bus.busy_out, bus.pkt_count_out); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_sid [5];
    exp_sid = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    for (int s = 0; s < NS; s++) drive(2'(s), 0, 1'b1);
    for (int p = 0; p < 5; p++) begin
      #1;
      checks++; if (bus.busy_out !== 1'b0 || bus.tvalid_out !== 1'b0) begin
        errors++; $display("FAIL rr_bubble pkt %0d got busy %0b tvalid %0b exp 0 0", p, bus.busy_out, bus.tvalid_out); end
      cyc();
      #1;
      checks++; if (bus.sid_out !== exp_sid[p] || bus.busy_out !== 1'b1 || bus.tlast_out !== 1'b1) begin
        errors++; $display("FAIL rr_grant pkt %0d got sid %0d busy %0b tlast %0b exp %0d 1 1", p, bus.sid_out, bus.busy_out, bus.tlast_out, exp_sid[p]); end
      cyc();
    end
    bus.tvalid_in = '0;
    #1;
    checks++; if (bus.busy_out !== 1'b0 || bus.pkt_count_out !== 32'd5) begin
      errors++; $display("FAIL rr_count got busy %0b pkt %0d exp 0 5", bus.busy_out, bus.pkt_count_out); end
  endtask

  task automatic test_hold_grant();
    drive(2'd1, 0, 1'b0);
    #1;
    cyc();
    for (int b = 0; b < 4; b++) begin
      if (b == 1) drive(2'd0, 0, 1'b1);
      #1;
      checks++; if (bus.sid_out !== 3'd1 || bus.data_out !== exp_data(2'd1, b) || bus.tready_out !== 4'b0010) begin
        errors++; $display("FAIL hold_beat %0d got sid %0d tready %b data %h exp 1 0010 %h", b, bus.sid_out, bus.tready_out, bus.data_out[31:0], exp_data(2'd1, b)); end
      checks++; if (bus.tlast_out !== (b == 3)) begin
        errors++; $display("FAIL hold_tlast beat %0d got %0b exp %0b", b, bus.tlast_out, (b == 3)); end
      cyc();
      if (b < 3) drive(2'd1, b + 1, (b + 1) == 3);
      else bus.tvalid_in[1] = 1'b0;
    end
    #1;
    checks++; if (bus.busy_out !== 1'b0 || bus.pkt_count_out !== 32'd1) begin
      errors++; $display("FAIL hold_done got busy %0b pkt %0d exp 0 1", bus.busy_out, bus.pkt_count_out); end
    cyc();
    #1;
    checks++; if (bus.sid_out !== 3'd0 || bus.tready_out !== 4'b0001 || bus.tlast_out !== 1'b1) begin
      errors++; $display("FAIL hold_next got sid %0d tready %b tlast %0b exp 0 0001 1", bus.sid_out, bus.tready_out, bus.tlast_out); end
    cyc();
    bus.tvalid_in[0] = 1'b0;
    #1;
    checks++; if (bus.busy_out !== 1'b0 || bus.pkt_count_out !== 32'd2) begin
      errors++; $display("FAIL hold_count got busy %0b pkt %0d exp 0 2", bus.busy_out, bus.pkt_count_out); end
  endtask

  task automatic test_stall();
    drive(2'd3, 0, 1'b0);
    #1;
    cyc();
    #1;
    checks++; if (bus.sid_out !== 3'd3 || bus.data_out !== exp_data(2'd3, 0)) begin
      errors++; $display("FAIL stall_first got sid %0d data %h exp 3 %h", bus.sid_out, bus.data_out[31:0], exp_data(2'd3, 0)); end
    cyc();
    drive(2'd3, 1, 1'b0);
    bus.tready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.data_out !== exp_data(2'd3, 1) || bus.tvalid_out !== 1'b1 || bus.tready_out !== 4'b0000) begin
        errors++; $display("FAIL stall_hold cyc %0d got data %h tvalid %0b tready %b exp %h 1 0000", i, bus.data_out[31:0], bus.tvalid_out, bus.tready_out, exp_data(2'd3, 1)); end
      checks++; if (bus.pkt_count_out !== 32'd0 || bus.busy_out !== 1'b1) begin
        errors++; $display("FAIL stall_state cyc %0d got pkt %0d busy %0b exp 0 1", i, bus.pkt_count_out, bus.busy_out); end
      cyc();
    end
    bus.tready_in = 1'b1;
    #1;
    checks++; if (bus.data_out !== exp_data(2'd3, 1) || bus.tready_out !== 4'b1000) begin
      errors++; $display("FAIL stall_release got data %h tready %b exp %h 1000", bus.data_out[31:0], bus.tready_out, exp_data(2'd3, 1)); end
    cyc();
    drive(2'd3, 2, 1'b0);
    #1;
    checks++; if (bus.data_out !== exp_data(2'd3, 2)) begin
      errors++; $display("FAIL stall_beat2 got %h exp %h", bus.data_out[31:0], exp_data(2'd3, 2)); end
    cyc();
    drive(2'd3, 3, 1'b1);
    #1;
    checks++; if (bus.data_out !== exp_data(2'd3, 3) || bus.tlast_out !== 1'b1) begin
      errors++; $display("FAIL stall_beat3 got %h tlast %0b exp %h 1", bus.data_out[31:0], bus.tlast_out, exp_data(2'd3, 3)); end
    cyc();
    bus.tvalid_in[3] = 1'b0;
    #1;
    checks++; if (bus.busy_out !== 1'b0 || bus.pkt_count_out !== 32'd1) begin
      errors++; $display("FAIL stall_done got busy %0b pkt %0d exp 0 1", bus.busy_out, bus.pkt_count_out); end
  endtask

  task automatic test_valid_gap();
    drive(2'd0, 0, 1'b0);
    #1;
    cyc();
    #1;
    checks++; if (bus.sid_out !== 3'd0 || bus.data_out !== exp_data(2'd0, 0)) begin
      errors++; $display("FAIL gap_first got sid %0d data %h exp 0 %h", bus.sid_out, bus.data_out[31:0], exp_data(2'd0, 0)); end
    cyc();
    bus.tvalid_in[0] = 1'b0;
    drive(2'd2, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.tvalid_out !== 1'b0 || bus.busy_out !== 1'b1 || bus.sid_out !== 3'd0 || bus.tready_out !== 4'b0001) begin
        errors++; $display("FAIL gap_hold cyc %0d got tvalid %0b busy %0b sid %0d tready %b exp 0 1 0 0001", i, bus.tvalid_out, bus.busy_out, bus.sid_out, bus.tready_out); end
      cyc();
    end
    drive(2'd0, 1, 1'b0);
    #1;
    checks++; if (bus.data_out !== exp_data(2'd0, 1) || bus.tvalid_out !== 1'b1) begin
      errors++; $display("FAIL gap_resume got data %h tvalid %0b exp %h 1", bus.data_out[31:0], bus.tvalid_out, exp_data(2'd0, 1)); end
    cyc();
    drive(2'd0, 2, 1'b1);
    #1;
    checks++; if (bus.tlast_out !== 1'b1 || bus.sid_out !== 3'd0) begin
      errors++; $display("FAIL gap_last got tlast %0b sid %0d exp 1 0", bus.tlast_out, bus.sid_out); end
    cyc();
    bus.tvalid_in[0] = 1'b0;
    #1;
    checks++; if (bus.busy_out !== 1'b0 || bus.pkt_count_out !== 32'd1) begin
      errors++; $display("FAIL gap_done got busy %0b pkt %0d exp 0 1", bus.busy_out, bus.pkt_count_out); end
    cyc();
    #1;
    checks++; if (bus.sid_out !== 3'd2 || bus.data_out !== exp_data(2'd2, 0)) begin
      errors++; $display("FAIL gap_next got sid %0d data %h exp 2 %h", bus.sid_out, bus.data_out[31:0], exp_data(2'd2, 0)); end
    cyc();
    bus.tvalid_in[2] = 1'b0;
    #1;
    checks++; if (bus.pkt_count_out !== 32'd2) begin
      errors++; $display("FAIL gap_count got %0d exp 2", bus.pkt_count_out); end
  endtask

  task automatic test_mid_reset();
    drive(2'd1, 0, 1'b0);
    #1;
    cyc();
    #1;
    checks++; if (bus.sid_out !== 3'd1 || bus.busy_out !== 1'b1) begin
      errors++; $display("FAIL mrst_grant got sid %0d busy %0b exp 1 1", bus.sid_out, bus.busy_out); end
    cyc();
    drive(2'd1, 1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.busy_out !== 1'b0 || bus.tvalid_out !== 1'b0 || bus.tready_out !== 4'b0000 || bus.tlast_out !== 1'b0) begin
      errors++; $display("FAIL mrst_ctl got busy %0b tvalid %0b tready %b tlast %0b exp 0 0 0000 0", bus.busy_out, bus.tvalid_out, bus.tready_out, bus.tlast_out); end
    checks++; if (bus.sid_out !== 3'd0 || bus.data_out !== '0 || bus.tkeep_out !== '0) begin
      errors++; $display("FAIL mrst_data got sid %0d data %h tkeep %h exp 0 0 0", bus.sid_out, bus.data_out[31:0], bus.tkeep_out); end
    checks++; if (bus.pkt_count_out !== 32'd0) begin
      errors++; $display("FAIL mrst_pkt got %0d exp 0", bus.pkt_count_out); end
    cyc();
    drive(2'd3, 0, 1'b1);
    reset = 1'b0;
    #1;
    checks++; if (bus.busy_out !== 1'b0) begin
      errors++; $display("FAIL mrst_idle got busy %0b exp 0", bus.busy_out); end
    cyc();
    #1;
    checks++; if (bus.sid_out !== 3'd1 || bus.data_out !== exp_data(2'd1, 1)) begin
      errors++; $display("FAIL mrst_rescan got sid %0d data %h exp 1 %h", bus.sid_out, bus.data_out[31:0], exp_data(2'd1, 1)); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_source();
    reset_dut();
    test_round_robin();
    reset_dut();
    test_hold_grant();
    reset_dut();
    test_stall();
    reset_dut();
    test_valid_gap();
    test_mid_reset();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
